// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_CMD  = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;

    localparam logic [2:0] CMD_SPX = 3'd1;
    localparam logic [2:0] CMD_SPY = 3'd2;
    localparam logic [2:0] CMD_KP  = 3'd3;
    localparam logic [2:0] CMD_KI  = 3'd4;
    localparam logic [2:0] CMD_KD  = 3'd5;

    // A command byte is valid only when the whole byte is one of the five IDs.
    function automatic logic cmd_valid(input logic [7:0] b);
        return (b >= 8'd1) && (b <= 8'd5);
    endfunction

endpackage

// File: rtl/rx_strobe_sync.sv
// Brings the receiver done level into clk, emits one byte_stb per rising edge.
module rx_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_done,
    output logic byte_stb
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic fill1_q;
    logic fill2_q;
    logic stb_q;

    // Two-flop synchronizer; edge history only tracks genuine samples so a level
    // already high out of reset is never mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b1;
            fill1_q <= 1'b0;
            fill2_q <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            sync1_q <= rx_done;
            sync2_q <= sync1_q;
            fill1_q <= 1'b1;
            fill2_q <= fill1_q;
            if (fill2_q) begin
                prev_q <= sync2_q;
            end
            stb_q <= fill2_q & sync2_q & ~prev_q;
        end
    end

    assign byte_stb = stb_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames 5-byte UART commands and writes the addressed configuration register.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter logic [15:0] SPX_RST        = 16'd0,
    parameter logic [15:0] SPY_RST        = 16'd0,
    parameter logic [15:0] KP_RST         = 16'd0,
    parameter logic [15:0] KI_RST         = 16'd0,
    parameter logic [15:0] KD_RST         = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    output logic [15:0] setpoint_x,
    output logic [15:0] setpoint_y,
    output logic [15:0] kp,
    output logic [15:0] ki,
    output logic [15:0] kd,
    output logic        cfg_update,
    output logic [2:0]  cfg_id,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic          byte_stb;
    state_e        state_q, state_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [7:0]    dhi_q, dhi_d;
    logic [7:0]    dlo_q, dlo_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          upd_d;
    logic          err_d;
    logic [7:0]    csum_c;

    rx_strobe_sync u_rx_strobe_sync (
        .clk      (clk),
        .reset    (reset),
        .rx_done  (rx_done),
        .byte_stb (byte_stb)
    );

    assign csum_c = {5'd0, cmd_q} ^ dhi_q ^ dlo_q;

    // Frame FSM state, latched bytes and inter-byte timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
            cmd_q   <= '0;
            dhi_q   <= '0;
            dlo_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            dhi_q   <= dhi_d;
            dlo_q   <= dlo_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state decode; a strobe in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        dhi_d   = dhi_q;
        dlo_d   = dlo_q;
        tmo_d   = tmo_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;

        if (state_q != ST_SYNC) begin
            if (byte_stb) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LIMIT) begin
                err_d   = 1'b1;
                state_d = ST_SYNC;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (byte_stb) begin
            unique case (state_q)
                ST_SYNC: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cmd_valid(rx_byte)) begin
                        cmd_d   = rx_byte[2:0];
                        state_d = ST_DHI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_SYNC;
                    end
                end
                ST_DHI: begin
                    dhi_d   = rx_byte;
                    state_d = ST_DLO;
                end
                ST_DLO: begin
                    dlo_d   = rx_byte;
                    state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (rx_byte == csum_c) begin
                        upd_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_SYNC;
                end
                default: state_d = ST_SYNC;
            endcase
        end

        if (state_d == ST_SYNC) begin
            tmo_d = '0;
        end
    end

    // Register file, update/error pulses and saturating error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            setpoint_x <= SPX_RST;
            setpoint_y <= SPY_RST;
            kp         <= KP_RST;
            ki         <= KI_RST;
            kd         <= KD_RST;
            cfg_update <= 1'b0;
            cfg_id     <= '0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            cfg_update <= upd_d;
            frame_err  <= err_d;
            if (upd_d) begin
                cfg_id <= cmd_q;
                unique case (cmd_q)
                    CMD_SPX: setpoint_x <= {dhi_q, dlo_q};
                    CMD_SPY: setpoint_y <= {dhi_q, dlo_q};
                    CMD_KP:  kp         <= {dhi_q, dlo_q};
                    CMD_KI:  ki         <= {dhi_q, dlo_q};
                    CMD_KD:  kd         <= {dhi_q, dlo_q};
                    default: ;
                endcase
            end
            if (err_d && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller sequencing the UART receiver byte stream into the ball balancer's configuration registers (setpoints and PID gains). It synchronizes the receiver's done flag from the `fast_tick` domain, frames and validates 5-byte commands, and writes the addressed 16-bit register with a one-cycle update pulse to the PID core. Malformed or stalled frames are discarded and counted.

## Interface
- `TIMEOUT_CYCLES`, default 200000: maximum clk cycles between bytes inside a frame.
- `SPX_RST`, default 16'd0: reset value of `setpoint_x`.
- `SPY_RST`, default 16'd0: reset value of `setpoint_y`.
- `KP_RST` / `KI_RST` / `KD_RST`, default 16'd0: reset values of the gains.
- `clk` in 1: system clock. One clock for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `rx_byte` in 8: receiver `d_out`; stable whenever `rx_done` is high.
- `rx_done` in 1: receiver `rx_done_tick` (level, fast_tick domain); a rising edge marks a new byte.
- `setpoint_x`, `setpoint_y` out 16: position setpoints, two's complement.
- `kp`, `ki`, `kd` out 16: PID gains, unsigned.
- `cfg_update` out 1: one-cycle pulse in the cycle a register takes a new value.
- `cfg_id` out 3: command ID of the last write; held between pulses.
- `frame_err` out 1: one-cycle pulse on any discarded frame.
- `err_count` out 8: discarded-frame count, saturating at 255.

## Operation
- Frame: `0xAA` sync, CMD, DATA_HI, DATA_LO, CSUM. CSUM = CMD ^ DATA_HI ^ DATA_LO.
- CMD IDs: 1 = setpoint_x, 2 = setpoint_y, 3 = kp, 4 = ki, 5 = kd. All other IDs are invalid.
- Byte strobe: `rx_done` passes through a 2-flop synchronizer, then a rising-edge detect. Each edge produces exactly one `byte_stb`; `rx_byte` is sampled in that cycle.
- FSM states:
  - SYNC: on strobe, `0xAA` moves to CMD. Any other byte is dropped silently (no error).
  - CMD: ID 1–5 is latched and the FSM moves to DHI. Invalid ID raises `frame_err` and returns to SYNC.
  - DHI: latch the high byte, then move to DLO.
  - DLO: latch the low byte, then move to CSUM.
  - CSUM: on match, write the register, pulse `cfg_update`, set `cfg_id`, and go to SYNC. On mismatch, raise `frame_err`, leave registers unchanged, and go to SYNC.
- No escaping: `0xAA` inside CMD/DATA/CSUM is ordinary data.
- Timeout counter:
  - Runs only outside SYNC.
  - Clears on every strobe and on entering SYNC.
  - Reaching `TIMEOUT_CYCLES` raises `frame_err` and returns to SYNC.
- `err_count` increments on every `frame_err`. It holds at 255 and clears only on reset.

## Timing
- Reset (synchronous):
  - FSM goes to SYNC; timeout counter, latched bytes and synchronizer flops clear.
  - Outputs take `*_RST` values; `cfg_update`, `frame_err`, `err_count`, `cfg_id` = 0.
- Strobe latency: `byte_stb` is asserted 3 clk cycles after `rx_done` rises at the synchronizer input.
- CSUM handling: on the cycle after the CSUM strobe, the register, `cfg_update` and `cfg_id` change together. `frame_err` follows the same timing.
- Strobe and timeout expiry in the same cycle: the strobe wins and no error is raised.
- Reset mid-frame: the partial frame is lost with no `frame_err`. The next valid frame needs a fresh `0xAA`.
- `rx_done` high out of reset produces no strobe. Only 0→1 transitions seen after reset count.
- Back-to-back frames: a sync byte arriving the strobe right after CSUM is accepted. No dead cycles are required.

## Structure
- Package `uart_cmd_pkg`:
  - FSM state encoding (SYNC, CMD, DHI, DLO, CSUM).
  - `SYNC_BYTE` = 8'hAA.
  - CMD ID constants 1–5.
- Sub-module `rx_strobe_sync`: 2-flop synchronizer plus rising-edge detect, output `byte_stb`. Reused by any other fast_tick-domain consumer.
- Top holds the FSM, byte latches, checksum, timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`), register file and error counter.

## Test plan
- Reset → all registers at parameter defaults, `err_count` = 0, `cfg_update`/`frame_err` low.
- Frame AA 03 01 2C 2E → `kp` = 16'h012C, one `cfg_update` pulse, `cfg_id` = 3, no `frame_err`.
- Frame AA 01 FF 38 C6 → `setpoint_x` = 16'hFF38 (−200). Leading junk bytes 55 00 are ignored with no error.
- Frame AA 04 00 10 00 (bad CSUM) → `ki` unchanged, one `frame_err`, `err_count` = 1. Repeating 300 times leaves `err_count` = 255.
- Timeout and invalid CMD:
  - AA 05 00, then silence > `TIMEOUT_CYCLES` → `frame_err`, FSM in SYNC.
  - A following valid kd frame is accepted.
  - AA 07 … → `frame_err` at the CMD byte.
- Reset asserted between DATA_HI and DATA_LO → registers return to defaults, no `frame_err`. The tail bytes are ignored until the next `0xAA`.
